// File: rtl/melody_pkg.sv
// melody_pkg: shared types and constants for the melody sequencer slice.
// Holds the FSM state enum, note/duration field widths and ROM entry layout.
// Entry layout is {note[6:3], dur[2:0]}; dur 0 marks the end of the song.
package melody_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP,
    DONE
  } state_t;

  localparam int NOTE_W  = 4;
  localparam int DUR_W   = 3;
  localparam int ENTRY_W = NOTE_W + DUR_W;

  localparam int NOTE_MSB = 6;
  localparam int NOTE_LSB = 3;
  localparam int DUR_MSB  = 2;
  localparam int DUR_LSB  = 0;

  localparam logic [NOTE_W-1:0] REST_NOTE = 4'hF;

  function automatic logic [NOTE_W-1:0] entry_note(input logic [ENTRY_W-1:0] e);
    return e[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
    return e[DUR_MSB:DUR_LSB];
  endfunction

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [NOTE_W-1:0] n,
                                                  input logic [DUR_W-1:0] d);
    return {n, d};
  endfunction

endpackage

// File: rtl/melody_if.sv
// melody_if: control inputs and note-generator outputs of the melody sequencer.
// master = board-level switch/key logic side, slave = the sequencer itself.
// IDX_W must equal clog2(SONG_LEN) of the attached sequencer.
interface melody_if
  import melody_pkg::*;
#(
  parameter int IDX_W = 4
);
  logic              start;
  logic              stop;
  logic              loop;
  logic [NOTE_W-1:0] note;
  logic              note_en;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  step_idx;

  modport master (
    output start, stop, loop,
    input  note, note_en, busy, done, step_idx
  );

  modport slave (
    input  start, stop, loop,
    output note, note_en, busy, done, step_idx
  );
endinterface

// File: rtl/melody_rom.sv
// melody_rom: song table of {note, dur} entries with a one-cycle registered read.
// SONG_ID 0 is the pentatonic scale 0..9 then a terminator; 1 and 2 are short alternates.
// Addresses not listed read as 0, which is an end-of-song marker.
module melody_rom
  import melody_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int SONG_ID = 0
) (
  input  logic               clk,
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] data
);
  logic [7:0]         addr8;
  logic [ENTRY_W-1:0] entry;

  assign addr8 = 8'(addr);

  // Song tables; everything outside a table is a terminator.
  always_comb begin
    entry = '0;
    if (SONG_ID == 1) begin
      case (addr8)
        8'd0:    entry = mk_entry(4'd3, 3'd2);
        8'd1:    entry = mk_entry(REST_NOTE, 3'd1);
        8'd2:    entry = mk_entry(4'd5, 3'd1);
        8'd4:    entry = mk_entry(4'd7, 3'd1);
        8'd5:    entry = mk_entry(4'd1, 3'd2);
        8'd6:    entry = mk_entry(4'd9, 3'd1);
        8'd7:    entry = mk_entry(4'd2, 3'd1);
        default: entry = '0;
      endcase
    end else if (SONG_ID == 2) begin
      case (addr8)
        8'd0:    entry = mk_entry(4'd1, 3'd1);
        8'd1:    entry = mk_entry(REST_NOTE, 3'd1);
        8'd2:    entry = mk_entry(4'd2, 3'd1);
        8'd3:    entry = mk_entry(4'd4, 3'd2);
        8'd4:    entry = mk_entry(4'd6, 3'd1);
        8'd5:    entry = mk_entry(4'd8, 3'd1);
        8'd6:    entry = mk_entry(REST_NOTE, 3'd1);
        8'd7:    entry = mk_entry(4'd9, 3'd1);
        default: entry = '0;
      endcase
    end else begin
      case (addr8)
        8'd0:    entry = mk_entry(4'd0, 3'd1);
        8'd1:    entry = mk_entry(4'd1, 3'd1);
        8'd2:    entry = mk_entry(4'd2, 3'd1);
        8'd3:    entry = mk_entry(4'd3, 3'd1);
        8'd4:    entry = mk_entry(4'd4, 3'd1);
        8'd5:    entry = mk_entry(4'd5, 3'd1);
        8'd6:    entry = mk_entry(4'd6, 3'd1);
        8'd7:    entry = mk_entry(4'd7, 3'd1);
        8'd8:    entry = mk_entry(4'd8, 3'd1);
        8'd9:    entry = mk_entry(4'd9, 3'd2);
        default: entry = '0;
      endcase
    end
  end

  // Registered read: data reflects the address presented on the previous edge.
  always_ff @(posedge clk) begin
    data <= entry;
  end
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: walks the song ROM, timing each entry in beats and driving note/note_en.
// Build option MELODY_GAP_EN adds a silent GAP_TICKS articulation after every entry.
// stop aborts to IDLE on the next edge and beats start; loop is sampled at end of song.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int SONG_LEN       = 16,
  parameter int TICKS_PER_BEAT = 12500000,
  parameter int GAP_TICKS      = 1250000,
  parameter int SONG_ID        = 0
) (
  input logic     clk,
  input logic     reset,
  melody_if.slave mif
);
  localparam int IDX_W   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  // Sized for both beat and gap counts so the width does not change with the build option.
  localparam int CNT_MAX = (TICKS_PER_BEAT > GAP_TICKS) ? TICKS_PER_BEAT : GAP_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_BEAT - 1);
`ifdef MELODY_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
`endif
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SONG_LEN - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   step_idx, step_nxt;
  logic [NOTE_W-1:0]  note_q, note_nxt;
  logic [CNT_W-1:0]   tick, tick_nxt;
  logic [DUR_W-1:0]   beat, beat_nxt;
  logic [ENTRY_W-1:0] rom_q;
  logic [NOTE_W-1:0]  rom_note;
  logic [DUR_W-1:0]   rom_dur;
  logic               adv;

  // The ROM is addressed with the next index so the entry is ready during LOAD.
  melody_rom #(
    .ADDR_W  (IDX_W),
    .SONG_ID (SONG_ID)
  ) u_rom (
    .clk  (clk),
    .addr (step_nxt),
    .data (rom_q)
  );

  assign rom_note = entry_note(rom_q);
  assign rom_dur  = entry_dur(rom_q);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step_idx <= '0;
      note_q   <= '0;
      tick     <= '0;
      beat     <= '0;
    end else begin
      state    <= state_nxt;
      step_idx <= step_nxt;
      note_q   <= note_nxt;
      tick     <= tick_nxt;
      beat     <= beat_nxt;
    end
  end

  // Next-state logic: entry load, beat/tick timing, gap and song advance.
  always_comb begin
    state_nxt = state;
    step_nxt  = step_idx;
    note_nxt  = note_q;
    tick_nxt  = tick;
    beat_nxt  = beat;
    adv       = 1'b0;
    if (mif.stop) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (mif.start) begin
            state_nxt = LOAD;
            step_nxt  = '0;
          end
        end
        LOAD: begin
          if (rom_dur != '0) begin
            note_nxt  = rom_note;
            beat_nxt  = rom_dur;
            tick_nxt  = TICK_LAST;
            state_nxt = PLAY;
          end else if (mif.loop && step_idx != '0) begin
            step_nxt  = '0;
            state_nxt = LOAD;
          end else begin
            state_nxt = DONE;
          end
        end
        PLAY: begin
          if (tick != '0) begin
            tick_nxt = tick - 1'b1;
          end else if (beat != DUR_W'(1)) begin
            beat_nxt = beat - 1'b1;
            tick_nxt = TICK_LAST;
          end else begin
`ifdef MELODY_GAP_EN
            state_nxt = GAP;
            tick_nxt  = GAP_LAST;
`else
            adv = 1'b1;
`endif
          end
        end
`ifdef MELODY_GAP_EN
        GAP: begin
          if (tick != '0) tick_nxt = tick - 1'b1;
          else            adv      = 1'b1;
        end
`endif
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
      if (adv) begin
        if (step_idx == IDX_LAST) begin
          if (mif.loop) begin
            step_nxt  = '0;
            state_nxt = LOAD;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          step_nxt  = step_idx + 1'b1;
          state_nxt = LOAD;
        end
      end
    end
  end

  assign mif.note     = note_q;
  assign mif.note_en  = (state == PLAY) && (note_q != REST_NOTE);
  assign mif.busy     = (state != IDLE);
  assign mif.done     = (state == DONE);
  assign mif.step_idx = step_idx;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: two sequencers (terminated song, full-length song) share one stimulus stream.
// A timeline model predicts every cycle's outputs into per-DUT queues; a monitor pops and compares.
// Directed scenarios come first, then randomized start/stop/loop/reset traffic.
module tb_melody_sequencer;
  import melody_pkg::*;

  localparam int LEN = 8;
  localparam int T   = 4;
  localparam int G   = 2;
  localparam int IW  = 3;
`ifdef MELODY_GAP_EN
  localparam int GAPC = G;
`else
  localparam int GAPC = 0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FIN  = 2;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          note_en;
    logic [3:0]    note;
    logic [IW-1:0] idx;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic loop = 1'b0;

  always #5 clk = ~clk;

  melody_if #(.IDX_W(IW)) if0 ();
  melody_if #(.IDX_W(IW)) if1 ();

  assign if0.start = start;
  assign if0.stop  = stop;
  assign if0.loop  = loop;
  assign if1.start = start;
  assign if1.stop  = stop;
  assign if1.loop  = loop;

  melody_sequencer #(.SONG_LEN(LEN), .TICKS_PER_BEAT(T), .GAP_TICKS(G), .SONG_ID(1)) u0 (
    .clk(clk), .reset(reset), .mif(if0));
  melody_sequencer #(.SONG_LEN(LEN), .TICKS_PER_BEAT(T), .GAP_TICKS(G), .SONG_ID(2)) u1 (
    .clk(clk), .reset(reset), .mif(if1));

  rec_t q0[$];
  rec_t q1[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   sn[2][LEN];
  int   sd[2][LEN];
  int   mode[2];
  int   idx[2];
  int   pos[2];
  int   lnote[2];
  bit   lp;

  // Cycles an entry occupies counted from its LOAD cycle.
  function automatic int elen(input int k, input int i);
    return (sd[k][i] == 0) ? 1 : 1 + sd[k][i] * T + GAPC;
  endfunction

  // Timeline model: position inside the current entry decides the outputs.
  task automatic step(input int k, output rec_t r);
    if (reset) begin
      mode[k] = M_IDLE; idx[k] = 0; pos[k] = 0; lnote[k] = 0;
    end else if (stop) begin
      mode[k] = M_IDLE;
    end else begin
      case (mode[k])
        M_IDLE: if (start) begin mode[k] = M_RUN; idx[k] = 0; pos[k] = 0; end
        M_FIN:  mode[k] = M_IDLE;
        default: begin
          pos[k]++;
          if (pos[k] >= elen(k, idx[k])) begin
            if (sd[k][idx[k]] == 0) begin
              if (loop && idx[k] != 0) begin idx[k] = 0; pos[k] = 0; end
              else mode[k] = M_FIN;
            end else if (idx[k] == LEN - 1) begin
              if (loop) begin idx[k] = 0; pos[k] = 0; end
              else mode[k] = M_FIN;
            end else begin
              idx[k]++; pos[k] = 0;
            end
          end
        end
      endcase
    end
    if (mode[k] == M_RUN && pos[k] == 1 && sd[k][idx[k]] != 0) lnote[k] = sn[k][idx[k]];
    r.busy    = (mode[k] != M_IDLE);
    r.done    = (mode[k] == M_FIN);
    r.note_en = (mode[k] == M_RUN) && pos[k] >= 1 && pos[k] <= sd[k][idx[k]] * T
                && sn[k][idx[k]] != 15;
    r.note    = 4'(lnote[k]);
    r.idx     = IW'(idx[k]);
  endtask

  task automatic cyc(input bit rs, input bit st, input bit sp, input bit l);
    rec_t r;
    reset = rs; start = st; stop = sp; loop = l;
    step(0, r); q0.push_back(r);
    step(1, r); q1.push_back(r);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit l);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, l);
  endtask

  task automatic chk(input string nm, input rec_t a, input rec_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got busy=%b done=%b en=%b note=%0d idx=%0d, expected busy=%b done=%b en=%b note=%0d idx=%0d",
               nm, $time, a.busy, a.done, a.note_en, a.note, a.idx,
               e.busy, e.done, e.note_en, e.note, e.idx);
    end
  endtask

  // Monitor: one expected record per DUT per clock, compared just after the edge.
  initial begin
    rec_t a;
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = {if0.busy, if0.done, if0.note_en, if0.note, if0.step_idx};
        chk("seq_term", a, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = {if1.busy, if1.done, if1.note_en, if1.note, if1.step_idx};
        chk("seq_full", a, e);
      end
    end
  end

  initial begin
    sn[0] = '{3, 15, 5, 0, 7, 1, 9, 2};
    sd[0] = '{2, 1, 1, 0, 1, 2, 1, 1};
    sn[1] = '{1, 15, 2, 4, 6, 8, 15, 9};
    sd[1] = '{1, 1, 1, 2, 1, 1, 1, 1};
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_IDLE; idx[k] = 0; pos[k] = 0; lnote[k] = 0;
    end

    // Reset state, then reset held 3 cycles in the middle of a note.
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Full play-through without looping: done pulse then idle.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(80, 1'b0);

    // Looping playback with start held while busy, then stop.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    repeat (20) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    idle(70, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);

    // Stop during the second beat of entry 0, then replay from index 0.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(30, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // start and stop together while idle: stays idle.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b0);

    // Randomized traffic.
    lp = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) lp = ~lp;
      cyc($urandom_range(0, 599) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 89) == 0, lp);
    end
    idle(2, 1'b0);

    n_chk++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d records left, expected 0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a fixed melody by stepping through a song ROM of {note, duration} entries. Drives the 4-bit note index and enable inputs of the downstream note generator, which looks up the note's half-period and toggles the speaker pin. Owns tempo, note duration, rests, articulation gaps and looping. One instance sits between the board-level switch/key logic and the note generator.

## Interface
- SONG_LEN, 16: number of ROM entries (2..256); index width is clog2(SONG_LEN).
- TICKS_PER_BEAT, 12500000: clk cycles per beat (0.25 s at 50 MHz); must be ≥1.
- GAP_TICKS, 1250000: silent articulation cycles after each entry; must be ≥1; used only with MELODY_GAP_EN.
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  synchronous, active-high; all state cleared on the rising clk edge while high
- start  in  1  level-sampled; begins playback from entry 0 when idle
- stop  in  1  aborts playback
- loop  in  1  sampled at end of song; 1 = restart from entry 0
- note  out  4  note index to the note generator; holds its last value when idle
- note_en  out  1  enable to the note generator; high only while a non-rest note sounds
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when playback ends normally
- step_idx  out  clog2(SONG_LEN)  index of the current ROM entry

## Operation
- ROM entry is 7 bits: note[6:3], dur[2:0] in beats. note 4'hF = rest. dur 0 = end-of-song marker.
- States: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE: start=1 → LOAD, step_idx←0.
- LOAD: 1 cycle; the registered ROM output for step_idx becomes available.
  - dur≠0: latch note and dur, load beat and tick counters → PLAY.
  - dur=0 with loop=1 and step_idx≠0: step_idx←0 → LOAD.
  - dur=0 otherwise → DONE.
- PLAY: lasts exactly dur×TICKS_PER_BEAT cycles. The tick counter counts TICKS_PER_BEAT−1 down to 0; at 0 the beat counter decrements. When the last beat's tick reaches 0 → GAP (gap enabled) or advance (gap disabled).
- GAP: GAP_TICKS cycles with note_en=0, then advance.
- Advance: if step_idx=SONG_LEN−1, end of song: loop=1 → step_idx←0, LOAD; loop=0 → DONE. Otherwise step_idx+1 → LOAD.
- DONE: done=1 for one cycle → IDLE.
- note_en=1 only in PLAY with latched note≠4'hF. A rest sounds nothing, but its timing is identical to a note.
- stop=1 in any state → IDLE on the next edge; note_en=0 and done=0 that cycle.
- start while busy is ignored. start and stop together: stop wins.
- All counters are unsigned. Counter widths come from the parameters; no wrap-around is permitted inside the legal ranges.

## Timing
- Reset values: note=0, note_en=0, busy=0, done=0, step_idx=0, state=IDLE.
- start sampled at edge N → busy=1 after edge N (LOAD). note and note_en are valid after edge N+1.
- Each entry occupies 1 + dur×TICKS_PER_BEAT + GAP_TICKS cycles; without the gap, 1 + dur×TICKS_PER_BEAT.
- Between entries, note_en is low for at least the LOAD cycle, so consecutive repeated notes are audibly separated.
- done rises the cycle after the final LOAD/advance decision. busy falls one cycle after done.
- Reset asserted mid-note forces all outputs to their reset values after that edge.

## Configuration
- MELODY_GAP_EN defined: the GAP state exists and GAP_TICKS is used.
- MELODY_GAP_EN undefined: GAP is removed, PLAY goes directly to advance, and the GAP_TICKS parameter is ignored.

## Structure
- melody_pkg holds:
  - state enum (IDLE, LOAD, PLAY, GAP, DONE);
  - REST_NOTE = 4'hF;
  - NOTE_W = 4 and DUR_W = 3;
  - entry field bit positions.
- Sub-module melody_rom: address in, 7-bit entry out, synchronous read, contents as a case table. The default song is the 10-note pentatonic scale matching the note generator's 0..9 table, followed by a terminator.
- The sequencer holds the FSM, tick and beat counters, and the output registers.

## Test plan
All scenarios use TICKS_PER_BEAT=4 and GAP_TICKS=2.
- Reset held 3 cycles mid-PLAY → next cycle: note=0, note_en=0, busy=0, step_idx=0.
- start with entry0={3,2} → note=3 with note_en high for exactly 8 cycles. With the gap enabled, low for 2 gap cycles and 1 LOAD cycle before entry1.
- Entry {4'hF,1} (rest) → note_en=0 for its 4 PLAY cycles; step_idx still advances on schedule.
- Terminator at index 3, loop=0 → after entry2, done pulses exactly 1 cycle, then busy=0. With loop=1 → step_idx returns to 0 and entry0 replays with no done pulse.
- stop asserted during the 2nd beat of a note → note_en=0 and busy=0 after the next edge. A subsequent start replays from index 0.
- start and stop asserted in the same IDLE cycle → remains IDLE. start held while busy → no restart and step_idx unaffected.
